// File: rtl/nrzi_pkg.sv
// Shared types and defaults for the NRZI receive path.
package nrzi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RX   = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;
  localparam int         STUFF_LEN_DEF = 6;
  localparam logic       LEVEL_J       = 1'b1;
  localparam logic       LEVEL_K       = 1'b0;

endpackage

// File: rtl/nrzi_bit_unstuff.sv
// NRZI decode of each sampled level plus the run-of-ones counter that
// classifies the current bit as data, stuffed or a stuffing violation.
module nrzi_bit_unstuff
  import nrzi_pkg::*;
#(
  parameter int   STUFF_LEN = STUFF_LEN_DEF,
  parameter logic LINE_IDLE = LEVEL_J
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_en,
  input  logic din,
  input  logic se0,
  input  logic active,
  output logic bit_valid,
  output logic bit_data,
  output logic stuffed,
  output logic stuff_violation
);

  localparam int              OW       = $clog2(STUFF_LEN + 1);
  localparam logic [OW-1:0]   ONES_MAX = OW'(STUFF_LEN);

  logic          prev_level_reg, prev_level_next;
  logic [OW-1:0] ones_reg, ones_next;
  logic          at_limit;

  always_comb begin
    bit_valid       = din_en && !se0;
    bit_data        = ~(din ^ prev_level_reg);
    at_limit        = active && (ones_reg == ONES_MAX);
    stuffed         = bit_valid && at_limit && !bit_data;
    stuff_violation = bit_valid && at_limit && bit_data;
    prev_level_next = prev_level_reg;
    ones_next       = ones_reg;
    if (din_en) begin
      prev_level_next = se0 ? LINE_IDLE : din;
    end
    // The run only matters inside a packet; outside RX it is held at zero.
    if (!active) begin
      ones_next = '0;
    end else if (bit_valid) begin
      if (at_limit || !bit_data) begin
        ones_next = '0;
      end else begin
        ones_next = ones_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_level_reg <= LINE_IDLE;
      ones_reg       <= '0;
    end else begin
      prev_level_reg <= prev_level_next;
      ones_reg       <= ones_next;
    end
  end

endmodule

// File: rtl/nrzi_rx_decoder.sv
// NRZI receiver: sync hunt, LSB-first byte assembly and a single-entry
// valid/ready holding register, with EOP and error pulses.
module nrzi_rx_decoder
  import nrzi_pkg::*;
#(
  parameter int         STUFF_LEN = STUFF_LEN_DEF,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter logic       LINE_IDLE = LEVEL_J
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din_en,
  input  logic       din,
  input  logic       se0,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_eop,
  output logic       stuff_err,
  output logic       align_err,
  output logic       overrun,
  output logic       busy
);

  state_t     state_reg, state_next;
  logic [7:0] sync_reg, sync_next, sync_shift;
  logic [2:0] bitcnt_reg, bitcnt_next;
  logic [6:0] byte_reg, byte_next;
  logic [7:0] data_reg, data_next, full_byte;
  logic       valid_reg, valid_next;
  logic       eop_reg, eop_next;
  logic       stuff_err_reg, stuff_err_next;
  logic       align_reg, align_next;
  logic       overrun_reg, overrun_next;
  logic       bit_valid, bit_data, stuffed, stuff_violation;

  nrzi_bit_unstuff #(
    .STUFF_LEN (STUFF_LEN),
    .LINE_IDLE (LINE_IDLE)
  ) u_unstuff (
    .clk             (clk),
    .rst_n           (rst_n),
    .din_en          (din_en),
    .din             (din),
    .se0             (se0),
    .active          (state_reg == RX),
    .bit_valid       (bit_valid),
    .bit_data        (bit_data),
    .stuffed         (stuffed),
    .stuff_violation (stuff_violation)
  );

  always_comb begin
    state_next     = state_reg;
    sync_next      = sync_reg;
    bitcnt_next    = bitcnt_reg;
    byte_next      = byte_reg;
    data_next      = data_reg;
    valid_next     = valid_reg;
    eop_next       = 1'b0;
    stuff_err_next = 1'b0;
    align_next     = 1'b0;
    overrun_next   = 1'b0;
    sync_shift     = {bit_data, sync_reg[7:1]};
    full_byte      = {bit_data, byte_reg};
    if (valid_reg && out_ready) begin
      valid_next = 1'b0;
    end
    if (din_en) begin
      unique case (state_reg)
        IDLE: begin
          if (bit_valid) begin
            sync_next = sync_shift;
            if (sync_shift == SYNC_BYTE) begin
              state_next  = RX;
              bitcnt_next = '0;
            end
          end
        end
        RX: begin
          if (se0) begin
            eop_next   = 1'b1;
            align_next = (bitcnt_reg != 3'd0);
            state_next = IDLE;
          end else if (stuff_violation) begin
            stuff_err_next = 1'b1;
            state_next     = DROP;
          end else if (!stuffed) begin
            bitcnt_next = bitcnt_reg + 3'd1;
            if (bitcnt_reg == 3'd7) begin
              // A byte accepted this very edge frees the register for the new one.
              if (!valid_reg || out_ready) begin
                data_next  = full_byte;
                valid_next = 1'b1;
              end else begin
                overrun_next = 1'b1;
                state_next   = DROP;
              end
            end else begin
              byte_next[bitcnt_reg] = bit_data;
            end
          end
        end
        DROP: begin
          if (se0) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      sync_reg      <= '0;
      bitcnt_reg    <= '0;
      byte_reg      <= '0;
      data_reg      <= 8'h00;
      valid_reg     <= 1'b0;
      eop_reg       <= 1'b0;
      stuff_err_reg <= 1'b0;
      align_reg     <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sync_reg      <= sync_next;
      bitcnt_reg    <= bitcnt_next;
      byte_reg      <= byte_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      eop_reg       <= eop_next;
      stuff_err_reg <= stuff_err_next;
      align_reg     <= align_next;
      overrun_reg   <= overrun_next;
    end
  end

  assign out_data  = data_reg;
  assign out_valid = valid_reg;
  assign out_eop   = eop_reg;
  assign stuff_err = stuff_err_reg;
  assign align_err = align_reg;
  assign overrun   = overrun_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_nrzi_rx_decoder.sv
// Directed bench for nrzi_rx_decoder: expected bytes go into a queue and a
// monitor pops and compares them on every accepted handshake.
module tb_nrzi_rx_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din_en = 1'b0;
  logic       din = 1'b1;
  logic       se0 = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, out_eop, stuff_err, align_err, overrun, busy;

  int total = 0;
  int passed = 0;
  logic line = 1'b1;
  logic [7:0] exp_q[$];
  int n_eop = 0, n_stuff = 0, n_align = 0, n_ovr = 0;
  int b_eop = 0, b_stuff = 0, b_align = 0, b_ovr = 0;

  always #5 clk = ~clk;

  nrzi_rx_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din_en    (din_en),
    .din       (din),
    .se0       (se0),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_eop   (out_eop),
    .stuff_err (stuff_err),
    .align_err (align_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) begin
      passed++;
      $display("[%0t] %s: got %0h required %0h ok", $time, name, act, req);
    end else begin
      $display("[%0t] FAIL %s: got %0h required %0h", $time, name, act, req);
    end
  endtask

  // One strobe per clock; returns 1 time unit after the sampling edge.
  task automatic strobe(input logic lvl, input logic eop);
    din = lvl;
    se0 = eop;
    din_en = 1'b1;
    @(posedge clk);
    #1;
    din_en = 1'b0;
    se0 = 1'b0;
    line = eop ? 1'b1 : lvl;
  endtask

  // NRZI-encode decoded bits v[0..n-1]: 1 holds the line, 0 toggles it.
  task automatic send_bits(input logic [31:0] v, input int n);
    logic nl;
    for (int i = 0; i < n; i++) begin
      nl = v[i] ? line : ~line;
      strobe(nl, 1'b0);
    end
  endtask

  task automatic send_sync();
    send_bits(32'h80, 8);
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic snapshot();
    b_eop = n_eop;
    b_stuff = n_stuff;
    b_align = n_align;
    b_ovr = n_ovr;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] lv_sync;
    logic [7:0] lv_byte;
    logic [7:0] exp;

    fork
      forever begin
        @(negedge clk);
        if (out_eop)   n_eop++;
        if (stuff_err) n_stuff++;
        if (align_err) n_align++;
        if (overrun)   n_ovr++;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("[%0t] FAIL sb_unexpected_byte: got %0h required none", $time, out_data);
          end else begin
            exp = exp_q.pop_front();
            check("sb_byte", int'(out_data), int'(exp));
          end
        end
      end
    join_none

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 8'h00);
    check("rst_busy", int'(busy), 0);
    check("rst_pulses", int'({out_eop, stuff_err, align_err, overrun}), 0);
    rst_n = 1'b1;

    // Basic byte from raw line levels
    out_ready = 1'b0;
    snapshot();
    lv_sync = 8'h2A;
    lv_byte = 8'h36;
    for (int i = 0; i < 8; i++) strobe(lv_sync[i], 1'b0);
    check("t1_busy_after_sync", int'(busy), 1);
    for (int i = 0; i < 7; i++) strobe(lv_byte[i], 1'b0);
    check("t1_valid_before_8th", int'(out_valid), 0);
    strobe(lv_byte[7], 1'b0);
    check("t1_valid_after_8th", int'(out_valid), 1);
    check("t1_data_after_8th", int'(out_data), 8'hA5);
    exp_q.push_back(8'hA5);
    out_ready = 1'b1;
    strobe(1'b0, 1'b1);
    check("t1_eop_pulse", int'(out_eop), 1);
    check("t1_busy_after_eop", int'(busy), 0);
    idle_cycle();
    check("t1_eop_count", n_eop - b_eop, 1);
    check("t1_err_count", (n_stuff - b_stuff) + (n_align - b_align) + (n_ovr - b_ovr), 0);
    check("t1_valid_drained", int'(out_valid), 0);

    // Stuffing: 0x7F (stuffed 0 after six 1s) then 0x00
    snapshot();
    exp_q.push_back(8'h7F);
    exp_q.push_back(8'h00);
    send_sync();
    send_bits(32'h0000_00BF, 17);
    strobe(1'b0, 1'b1);
    idle_cycle();
    check("t2_stuff_err_count", n_stuff - b_stuff, 0);
    check("t2_eop_count", n_eop - b_eop, 1);
    check("t2_queue_empty", exp_q.size(), 0);

    // Stuff violation: seven decoded 1s
    snapshot();
    send_sync();
    send_bits(32'h7F, 7);
    check("t3_stuff_err_pulse", int'(stuff_err), 1);
    check("t3_busy_in_drop", int'(busy), 1);
    check("t3_no_byte", int'(out_valid), 0);
    send_bits(32'h0, 3);
    check("t3_busy_still", int'(busy), 1);
    strobe(1'b0, 1'b1);
    check("t3_busy_after_se0", int'(busy), 0);
    idle_cycle();
    check("t3_stuff_count", n_stuff - b_stuff, 1);
    check("t3_no_eop", n_eop - b_eop, 0);

    // Backpressure: second byte overruns
    out_ready = 1'b0;
    snapshot();
    exp_q.push_back(8'h11);
    send_sync();
    send_bits(32'h11, 8);
    strobe(1'b0, 1'b1);
    send_sync();
    send_bits(32'h22, 8);
    check("t4_overrun_pulse", int'(overrun), 1);
    check("t4_data_held", int'(out_data), 8'h11);
    check("t4_valid_held", int'(out_valid), 1);
    check("t4_busy_drop", int'(busy), 1);
    strobe(1'b0, 1'b1);
    check("t4_idle_after_se0", int'(busy), 0);
    out_ready = 1'b1;
    idle_cycle();
    idle_cycle();
    check("t4_eop_count", n_eop - b_eop, 1);
    check("t4_overrun_count", n_ovr - b_ovr, 1);
    check("t4_valid_drained", int'(out_valid), 0);

    // Backpressure released on the completing edge of the second byte
    out_ready = 1'b0;
    snapshot();
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send_sync();
    send_bits(32'h11, 8);
    strobe(1'b0, 1'b1);
    send_sync();
    send_bits(32'h22, 7);
    out_ready = 1'b1;
    send_bits(32'h0, 1);
    check("t4b_no_overrun", int'(overrun), 0);
    check("t4b_data_22", int'(out_data), 8'h22);
    check("t4b_valid", int'(out_valid), 1);
    strobe(1'b0, 1'b1);
    idle_cycle();
    check("t4b_overrun_count", n_ovr - b_ovr, 0);
    check("t4b_eop_count", n_eop - b_eop, 2);
    check("t4b_queue_empty", exp_q.size(), 0);

    // Alignment error
    snapshot();
    send_sync();
    send_bits(32'h5, 3);
    strobe(1'b0, 1'b1);
    check("t5_align_pulse", int'(align_err), 1);
    check("t5_eop_pulse", int'(out_eop), 1);
    check("t5_no_valid", int'(out_valid), 0);
    idle_cycle();
    check("t5_align_count", n_align - b_align, 1);

    // Reset mid-packet with a byte held
    out_ready = 1'b0;
    send_sync();
    send_bits(32'hA5, 8);
    strobe(1'b0, 1'b1);
    send_sync();
    send_bits(32'hA5, 4);
    rst_n = 1'b0;
    strobe(~line, 1'b0);
    rst_n = 1'b1;
    line = 1'b1;
    check("t6_valid_cleared", int'(out_valid), 0);
    check("t6_busy_cleared", int'(busy), 0);
    check("t6_data_cleared", int'(out_data), 8'h00);
    check("t6_pulses_clear", int'({out_eop, stuff_err, align_err, overrun}), 0);
    out_ready = 1'b1;
    snapshot();
    exp_q.push_back(8'h3C);
    send_sync();
    send_bits(32'h3C, 8);
    strobe(1'b0, 1'b1);
    idle_cycle();
    idle_cycle();
    check("t6_eop_count", n_eop - b_eop, 1);
    check("t6_err_count", (n_stuff - b_stuff) + (n_align - b_align) + (n_ovr - b_ovr), 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/nrzi_rx_decoder.md
Name: nrzi_rx_decoder

Overview:
- Serial line receiver that undoes NRZI line coding. A decoded bit is 1 when the line holds its level and 0 when the line toggles.
- Hunts for a sync pattern, removes stuffed bits, assembles LSB-first bytes and delivers them over a valid/ready interface.
- Reports end-of-packet and error conditions.
- Sits between the line sampler (one sample per `din_en` strobe) and the packet-layer byte consumer.

Parameters:
- `STUFF_LEN`, default 6: consecutive decoded 1s after which the next bit is a stuffed 0.
- `SYNC_BYTE`, default 8'h80: decoded sync pattern, first received bit in bit 0.
- `LINE_IDLE`, default 1'b1: idle (J) line level. Also the reset value of the previous-level register.

Ports:
- `clk`  input  1  system clock, all logic on rising edge
- `rst_n`  input  1  synchronous active-low reset
- `din_en`  input  1  sample strobe; `din`/`se0` are valid only when high
- `din`  input  1  sampled NRZI line level
- `se0`  input  1  line end-of-packet condition, qualified by `din_en`
- `out_data`  output  8  received byte
- `out_valid`  output  1  `out_data` holds an unconsumed byte
- `out_ready`  input  1  consumer accepts byte when high together with `out_valid`
- `out_eop`  output  1  one-cycle pulse: packet ended cleanly
- `stuff_err`  output  1  one-cycle pulse: stuffing violation
- `align_err`  output  1  one-cycle pulse: EOP with partial byte
- `overrun`  output  1  one-cycle pulse: byte lost because holding register was full
- `busy`  output  1  state != IDLE

Behaviour:
- Reset (synchronous, `rst_n`=0 on a rising edge):
  - state=IDLE; prev_level=`LINE_IDLE`; ones count, bit count and sync shift register cleared.
  - `out_data`=8'h00, `out_valid`=0, all pulse outputs 0, `busy`=0.
  - Reset mid-packet discards the partial byte and any held byte.
- Decoding:
  - Only cycles with `din_en`=1 advance bit logic. prev_level updates to `din` on every such cycle in every state.
  - `bit` = ~(`din` ^ prev_level).
  - When `se0`=1, no bit is decoded and prev_level reloads `LINE_IDLE`.
- State IDLE:
  - Shift `bit` into the 8-bit sync register, new bit entering at bit 7, so the first-received bit ends at bit 0.
  - When the register equals `SYNC_BYTE`: go to RX and clear the bit and ones counters.
  - `se0` is ignored apart from the prev_level reload.
- State RX, per strobe:
  - `se0`=1 and bit count==0: `out_eop` pulse, go to IDLE.
  - `se0`=1 and bit count!=0: `align_err` and `out_eop` pulse, partial byte dropped, go to IDLE.
  - ones==`STUFF_LEN` and `bit`=0: stuffed bit, discarded, ones cleared.
  - ones==`STUFF_LEN` and `bit`=1: `stuff_err` pulse, go to DROP.
  - Otherwise data bit: written to byte position bit count (LSB first); ones increments on 1 and clears on 0.
  - On the 8th data bit the byte is complete and bit count wraps to 0.
- Byte handoff:
  - Holding register free, or `out_valid`&&`out_ready` in the same cycle: load `out_data`, `out_valid`=1 from the next cycle. Latency is 1 clock from the 8th-bit strobe edge.
  - Otherwise: `overrun` pulse, byte dropped, go to DROP.
- State DROP: ignore bits until a strobe with `se0`=1, then go to IDLE with no `out_eop`.
- Output handshake:
  - `out_valid` stays high and `out_data` stays stable until accepted (`out_valid`&&`out_ready` on an edge).
  - The held byte survives EOP, errors and the return to IDLE.
- All outputs are registered. Pulses last exactly one clock.

Decomposition:
- Shared package `nrzi_pkg`: state enum {IDLE, RX, DROP}, default `SYNC_BYTE`, `STUFF_LEN`, J/K level constants.
- One sub-module, `nrzi_bit_unstuff`: NRZI decode plus ones counter, producing `bit_valid`/`bit`/`stuffed`/`stuff_violation` per strobe.
- Sync hunt, byte assembly and handshake stay in the top module.

Test Plan:
- Basic byte:
  - Stimulus: line levels (strobe every cycle, starting from idle 1) = 0,1,0,1,0,1,0,0 (sync), then 0,1,1,0,1,1,0,0 (byte 0xA5), then `se0`=1 with `out_ready`=1.
  - Required response: `out_valid` with `out_data`=8'hA5 one cycle after the 8th data strobe; `out_eop` pulse; no error pulses.
- Stuffing:
  - Stimulus: sync, then byte 0x7F followed by 0x00, i.e. six 1s, the 7th bit needing a stuffed 0, the stuffed 0 inserted on the line.
  - Required response: bytes 8'h7F and 8'h00 received; `stuff_err`=0.
- Stuff violation:
  - Stimulus: sync, then seven consecutive decoded 1s.
  - Required response: `stuff_err` pulse on the 7th; no byte delivered; `busy`=1 until `se0`; then IDLE with no `out_eop`.
- Backpressure and overrun:
  - Stimulus: `out_ready`=0, two sync-framed bytes 0x11, 0x22.
  - Required response: `out_data` stays 8'h11; `overrun` pulse at the second byte; state DROP.
  - Repeat with `out_ready` rising on the same cycle the second byte completes: 0x22 loads, no overrun.
- Alignment:
  - Stimulus: sync, 3 data bits, then `se0`.
  - Required response: `align_err` and `out_eop` pulse in the same cycle; no `out_valid`.
- Reset mid-packet:
  - Stimulus: assert `rst_n`=0 for one cycle during the 5th data bit while a previous byte is held.
  - Required response: `out_valid`=0, `busy`=0, all pulses 0; the next full sync+byte decodes correctly.
